// File: rtl/ad7606_emulator.sv
// Device-side model of the AD7606 parallel interface: CONVST/BUSY conversion timing
// followed by CS_N/RD_N readout of the last completed conversion on DB.
module ad7606_emulator #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CONV_CYCLES = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reset_dev,
    input  logic                     convst,
    input  logic                     cs_n,
    input  logic                     rd_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     busy,
    output logic                     frstdata,
    output logic [DATA_W-1:0]        db,
    output logic                     db_oe
);
    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  snapshot_q, snapshot_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  results_q, results_d;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic                           busy_q, busy_d;
    logic                           frstdata_q, frstdata_d;
    logic [DATA_W-1:0]              db_q, db_d;
    logic                           db_oe_q, db_oe_d;
    logic                           strb_q, strb_d;
    logic                           convst_q, convst_d;

    logic strb;
    logic strb_fall;
    logic strb_rise;
    logic conv_start;
    logic conv_done;

    // strb high means the controller is strobing (CS_N and RD_N both low)
    assign strb       = ~cs_n & ~rd_n;
    assign strb_fall  = strb & ~strb_q;
    assign strb_rise  = ~strb & strb_q;
    assign conv_start = (state_q == S_IDLE) & convst & ~convst_q & ~reset_dev;
    assign conv_done  = (state_q == S_CONV) & (cnt_q == CNT_LAST) & ~reset_dev;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (conv_start) state_d = S_CONV;
            S_CONV: if (conv_done)  state_d = S_IDLE;
        endcase
        if (reset_dev) state_d = S_IDLE;
    end

    // Datapath / output next values; later assignments take priority
    always_comb begin
        cnt_d      = cnt_q;
        snapshot_d = snapshot_q;
        results_d  = results_q;
        rd_ptr_d   = rd_ptr_q;
        busy_d     = busy_q;
        frstdata_d = frstdata_q;
        db_d       = db_q;
        db_oe_d    = strb;
        strb_d     = strb;
        convst_d   = convst;

        if (conv_start) begin
            snapshot_d = ch_data;
            cnt_d      = '0;
            busy_d     = 1'b1;
        end else if (state_q == S_CONV) begin
            cnt_d = conv_done ? '0 : cnt_q + CNT_W'(1);
        end

        if (strb_fall) begin
            db_d       = results_q[rd_ptr_q];
            frstdata_d = (rd_ptr_q == '0);
        end

        if (strb_rise) begin
            frstdata_d = 1'b0;
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        // Completion rewinds the read pointer even if a strobe just ended
        if (conv_done) begin
            results_d = snapshot_q;
            rd_ptr_d  = '0;
            busy_d    = 1'b0;
        end

        if (reset_dev) begin
            busy_d     = 1'b0;
            results_d  = '0;
            rd_ptr_d   = '0;
            frstdata_d = 1'b0;
            cnt_d      = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            snapshot_q <= '0;
            results_q  <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            frstdata_q <= 1'b0;
            db_q       <= '0;
            db_oe_q    <= 1'b0;
            strb_q     <= 1'b0;
            convst_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            snapshot_q <= snapshot_d;
            results_q  <= results_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            frstdata_q <= frstdata_d;
            db_q       <= db_d;
            db_oe_q    <= db_oe_d;
            strb_q     <= strb_d;
            convst_q   <= convst_d;
        end
    end

    assign busy     = busy_q;
    assign frstdata = frstdata_q;
    assign db       = db_q;
    assign db_oe    = db_oe_q;

endmodule
